// File: rtl/incr_count_sequencer_if.sv
// Bundle between the count sequencer and its environment: the run-control
// inputs (start/init/limit), the status outputs and the wiring to the
// external combinational incrementor.
// master: drives the run controls and returns the incrementor result.
// slave:  the sequencer itself.
interface incr_count_sequencer_if #(
  parameter int unsigned N = 8
);
  logic         start;
  logic [N-1:0] init;
  logic [N-1:0] limit;
  logic [N-1:0] inc_a;
  logic [N-1:0] inc_s;
  logic         inc_co;
  logic [N-1:0] count;
  logic         busy;
  logic         done;
  logic         wrapped;

  modport master (
    output start, init, limit, inc_s, inc_co,
    input  inc_a, count, busy, done, wrapped
  );

  modport slave (
    input  start, init, limit, inc_s, inc_co,
    output inc_a, count, busy, done, wrapped
  );
endinterface

// File: rtl/incr_count_sequencer.sv
// Count sequencer in front of an N-bit combinational incrementor.
// Loads init on an accepted start, then captures the incrementor's sum each
// step until count reaches limit, pulses done for one cycle and returns to
// idle. wrapped records any captured carry-out during the run.
// Optional macro INCR_SETTLE_EN: each step takes two cycles (check, then
// capture) so the incrementor gets a two-cycle settle window.
module incr_count_sequencer #(
  parameter int unsigned N = 8
) (
  input logic                    clk,
  input logic                    reset,
  incr_count_sequencer_if.slave  bus
);

`ifdef INCR_SETTLE_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN_CHK, S_RUN_CAP, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

  state_t       r_state;
  state_t       w_next_state;
  logic         w_load;
  logic         w_cap;
  logic         w_at_limit;
  logic [N-1:0] r_count;
  logic         r_wrapped;

  assign w_at_limit = (r_count == bus.limit);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and datapath strobes
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_cap        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load = 1'b1;
`ifdef INCR_SETTLE_EN
          w_next_state = S_RUN_CHK;
`else
          w_next_state = S_RUN;
`endif
        end
      end
`ifdef INCR_SETTLE_EN
      S_RUN_CHK: begin
        if (w_at_limit) w_next_state = S_DONE;
        else            w_next_state = S_RUN_CAP;
      end
      S_RUN_CAP: begin
        w_cap        = 1'b1;
        w_next_state = S_RUN_CHK;
      end
`else
      S_RUN: begin
        if (w_at_limit) w_next_state = S_DONE;
        else            w_cap = 1'b1;
      end
`endif
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Count register and sticky wrap flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_wrapped <= 1'b0;
    end else if (w_load) begin
      r_count   <= bus.init;
      r_wrapped <= 1'b0;
    end else if (w_cap) begin
      r_count <= bus.inc_s;
      if (bus.inc_co) r_wrapped <= 1'b1;
    end
  end

  assign bus.inc_a   = r_count;
  assign bus.count   = r_count;
  assign bus.wrapped = r_wrapped;
  assign bus.done    = (r_state == S_DONE);
`ifdef INCR_SETTLE_EN
  assign bus.busy    = (r_state == S_RUN_CHK) || (r_state == S_RUN_CAP);
`else
  assign bus.busy    = (r_state == S_RUN);
`endif

endmodule
